// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern controller: pattern codes, FSM states, config layout.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package vga_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int DB_CNT_W            = 20;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  // Same bit layout as the switch bank: SW[3:2] speed, SW[1:0] pattern.
  typedef struct packed {
    logic [1:0] speed;
    pattern_e   pattern;
  } cfg_t;

  // True when the frame count just reached is a multiple of 2^speed; speed 3 never advances.
  function automatic logic phase_due(input logic [1:0] speed, input logic [7:0] cnt);
    logic due;
    due = 1'b0;
    case (speed)
      2'd0:    due = 1'b1;
      2'd1:    due = (cnt[0] == 1'b0);
      2'd2:    due = (cnt[1:0] == 2'b00);
      default: due = 1'b0;
    endcase
    return due;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus stability counter for a raw switch vector.
// Latency: 2 sync cycles, then CYCLES+1 cycles of a steady synchronized value before sw_db follows.
// Backpressure: none; output simply holds the last accepted value.
module sw_debounce
  import vga_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             CLK_50,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0]    sync1;
  logic [WIDTH-1:0]    sync2;
  logic [WIDTH-1:0]    cand;
  logic [DB_CNT_W-1:0] cnt;

  // Bring the asynchronous switches into the clock domain.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Any change restarts the count; the candidate is accepted once the count saturates.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      cand  <= '0;
      cnt   <= '0;
      sw_db <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      sw_db <= cand;
    end else begin
      cnt <= cnt + DB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Applies debounced switch settings (pattern/speed) at frame boundaries and runs frame/phase counters.
// Latency: config lands 2 cycles after the frame_tick that ends a pending period; outputs registered.
// Backpressure: none; changes seen while pending are absorbed and the latest one is applied.
module vga_pattern_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       CLK_50,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       v_sync,
  output logic [1:0] pattern_sel,
  output logic [7:0] anim_phase,
  output logic [7:0] frame_cnt,
  output logic       cfg_update,
  output logic [7:0] LED
);

  logic [3:0] sw_db_raw;
  cfg_t       sw_cfg;
  logic       vs_prev;
  logic       frame_tick;
  state_e     state;
  state_e     state_nxt;
  logic       apply;
  logic       cfg_differs;
  logic [1:0] speed;
  pattern_e   pat_nxt;
  logic [1:0] spd_nxt;
  logic [7:0] cnt_nxt;
  logic [7:0] phase_nxt;

  sw_debounce #(
    .WIDTH  (4),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .CLK_50 (CLK_50),
    .RST_N  (RST_N),
    .sw_raw (SW),
    .sw_db  (sw_db_raw)
  );

  assign sw_cfg      = cfg_t'(sw_db_raw);
  assign cfg_differs = (sw_db_raw != {speed, pattern_sel});

  // Flag the single cycle following the end of the vertical sync pulse.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      vs_prev    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= v_sync;
      frame_tick <= v_sync & ~vs_prev;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait for a differing setting, hold it until the next frame boundary, then apply for one cycle.
  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_differs) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (!cfg_differs)    state_nxt = ST_IDLE;
        else if (frame_tick) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        apply     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the counters and active config; a pattern change wins over a phase step.
  always_comb begin
    cnt_nxt   = frame_cnt + {7'd0, frame_tick};
    pat_nxt   = pattern_e'(pattern_sel);
    spd_nxt   = speed;
    phase_nxt = anim_phase;
    if (frame_tick && phase_due(speed, cnt_nxt)) begin
      phase_nxt = anim_phase + 8'd1;
    end
    if (apply) begin
      pat_nxt = sw_cfg.pattern;
      spd_nxt = sw_cfg.speed;
      if (sw_cfg.pattern != pattern_sel) begin
        phase_nxt = 8'd0;
      end
    end
  end

  // Register every output, LED included, from the next-state values.
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      pattern_sel <= 2'd0;
      speed       <= 2'd0;
      anim_phase  <= 8'd0;
      frame_cnt   <= 8'd0;
      cfg_update  <= 1'b0;
      LED         <= 8'd0;
    end else begin
      pattern_sel <= pat_nxt;
      speed       <= spd_nxt;
      anim_phase  <= phase_nxt;
      frame_cnt   <= cnt_nxt;
      cfg_update  <= apply;
      LED         <= {pat_nxt, spd_nxt, cnt_nxt[7:4]};
    end
  end

endmodule
